// File: rtl/arm_shift_pkg.sv
// rtl/arm_shift_pkg.sv - shared encodings and clamp constants for the register-shift sequencer
package arm_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

  localparam int SHAMT_CLAMP_LOGIC = 33;
  localparam int SHAMT_CLAMP_ASR   = 32;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one iteration of the narrow shifter: 0..BITS_PER_CYCLE positions
// with type-specific fill; carry_o is the last bit moved out (carry_i when amt_i is 0).
module shift_step
  import arm_shift_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  localparam int AW            = $clog2(BITS_PER_CYCLE + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    amt_i,
  input  shift_type_e      type_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] d;
  logic             c;

  always_comb begin
    d = data_i;
    c = carry_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (AW'(i) < amt_i) begin
        unique case (type_i)
          SH_LSL: begin c = d[WIDTH-1]; d = {d[WIDTH-2:0], 1'b0};     end
          SH_LSR: begin c = d[0];       d = {1'b0, d[WIDTH-1:1]};     end
          SH_ASR: begin c = d[0];       d = {d[WIDTH-1], d[WIDTH-1:1]}; end
          default: begin c = d[0];      d = {d[0], d[WIDTH-1:1]};     end
        endcase
      end
    end
    data_o  = d;
    carry_o = c;
  end

endmodule

// File: rtl/reg_shift_sequencer.sv
// rtl/reg_shift_sequencer.sv - multi-cycle register-specified shifter that stalls EXE
// until the ARM Val2 and shifter carry-out are ready.
module reg_shift_sequencer
  import arm_shift_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] val_rm_i,
  input  logic [7:0]       rs_amount_i,
  input  logic [1:0]       shift_type_i,
  input  logic             carry_in_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o
);

  localparam int AW = $clog2(BITS_PER_CYCLE + 1);

  seq_state_e       state_q, state_d;
  shift_type_e      type_q, type_d;
  logic [5:0]       rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;

  shift_type_e      req_type;
  logic [5:0]       cnt;
  logic             accept;
  logic [AW-1:0]    step_amt;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  assign req_type = shift_type_e'(shift_type_i);
  assign accept   = (state_q == ST_IDLE || state_q == ST_DONE) && start_i && !flush_i;
  assign step_amt = (rem_q >= 6'(BITS_PER_CYCLE)) ? AW'(BITS_PER_CYCLE) : rem_q[AW-1:0];

  // Clamping the count makes the >=32 ARM edge cases fall out of plain iteration.
  always_comb begin
    cnt = {1'b0, rs_amount_i[4:0]};
    unique case (req_type)
      SH_LSL, SH_LSR:
        cnt = (rs_amount_i > 8'(SHAMT_CLAMP_LOGIC)) ? 6'(SHAMT_CLAMP_LOGIC) : rs_amount_i[5:0];
      SH_ASR:
        cnt = (rs_amount_i > 8'(SHAMT_CLAMP_ASR)) ? 6'(SHAMT_CLAMP_ASR) : rs_amount_i[5:0];
      default: cnt = {1'b0, rs_amount_i[4:0]};
    endcase
  end

  shift_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .data_i  (result_q),
    .amt_i   (step_amt),
    .type_i  (type_q),
    .carry_i (carry_q),
    .data_o  (step_data),
    .carry_o (step_carry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      type_q   <= SH_LSL;
      rem_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = (cnt == 6'd0) ? ST_DONE : ST_SHIFT;
        else        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (flush_i)                     state_d = ST_IDLE;
        else if (rem_q == 6'(step_amt))  state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero count covers both rs==0 and a rotate by a multiple of 32.
  always_comb begin
    type_d   = type_q;
    rem_d    = rem_q;
    result_d = result_q;
    carry_d  = carry_q;
    if (accept) begin
      type_d   = req_type;
      result_d = val_rm_i;
      rem_d    = cnt;
      if (cnt == 6'd0) begin
        carry_d = (rs_amount_i == 8'd0) ? carry_in_i : val_rm_i[WIDTH-1];
      end
    end else if (state_q == ST_SHIFT && !flush_i) begin
      result_d = step_data;
      carry_d  = step_carry;
      rem_d    = rem_q - 6'(step_amt);
    end
  end

  always_comb begin
    busy_o  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    stall_o = (state_q == ST_SHIFT);
    done_o  = (state_q == ST_DONE);
  end

  assign result_o    = result_q;
  assign carry_out_o = carry_q;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// tb/tb_reg_shift_sequencer.sv - directed self-checking bench, one and four bits per cycle.
module tb_reg_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush, carry_in;
  logic [31:0] val_rm;
  logic [7:0]  rs_amount;
  logic [1:0]  shift_type;

  logic        busy1, stall1, done1, c1;
  logic [31:0] r1;
  logic        busy4, stall4, done4, c4;
  logic [31:0] r4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_shift_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .val_rm_i(val_rm), .rs_amount_i(rs_amount), .shift_type_i(shift_type),
    .carry_in_i(carry_in), .busy_o(busy1), .stall_o(stall1), .done_o(done1),
    .result_o(r1), .carry_out_o(c1)
  );

  reg_shift_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .val_rm_i(val_rm), .rs_amount_i(rs_amount), .shift_type_i(shift_type),
    .carry_in_i(carry_in), .busy_o(busy4), .stall_o(stall4), .done_o(done4),
    .result_o(r4), .carry_out_o(c4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat4(input logic [1:0] t, input logic [7:0] rs);
    int cnt;
    if (t == 2'b11) cnt = int'(rs[4:0]);
    else if (t == 2'b10) cnt = (rs > 8'd32) ? 32 : int'(rs);
    else cnt = (rs > 8'd33) ? 33 : int'(rs);
    return 1 + (cnt + 3) / 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] t, input logic [31:0] v,
                        input logic [7:0] rs, input logic cin, input logic [31:0] exp_r,
                        input logic exp_c, input int exp_lat, input bit no_stall);
    int cyc, l1, l4;
    logic [31:0] g1, g4;
    logic gc1, gc4, stall_seen;
    @(negedge clk);
    shift_type = t; val_rm = v; rs_amount = rs; carry_in = cin; start = 1'b1;
    tick();
    start = 1'b0;
    val_rm = 32'hA5A5_5A5A; rs_amount = 8'hFF; carry_in = ~cin;
    cyc = 1; l1 = 0; l4 = 0; stall_seen = 1'b0;
    g1 = '0; g4 = '0; gc1 = 1'b0; gc4 = 1'b0;
    while ((l1 == 0 || l4 == 0) && cyc < 60) begin
      if (stall1) stall_seen = 1'b1;
      if (done1 && l1 == 0) begin l1 = cyc; g1 = r1; gc1 = c1; end
      if (done4 && l4 == 0) begin l4 = cyc; g4 = r4; gc4 = c4; end
      if (l1 == 0 || l4 == 0) begin tick(); cyc++; end
    end
    check({tag, "_lat"}, 32'(l1), 32'(exp_lat));
    check({tag, "_res"}, g1, exp_r);
    check({tag, "_c"}, {31'd0, gc1}, {31'd0, exp_c});
    check({tag, "_lat4"}, 32'(l4), 32'(lat4(t, rs)));
    check({tag, "_res4"}, g4, exp_r);
    check({tag, "_c4"}, {31'd0, gc4}, {31'd0, exp_c});
    if (no_stall) check({tag, "_nostall"}, {31'd0, stall_seen}, 32'd0);
  endtask

  initial begin
    int cyc, dones;
    rst = 1'b1; start = 1'b0; flush = 1'b0; carry_in = 1'b0;
    val_rm = '0; rs_amount = '0; shift_type = '0;
    repeat (2) tick();
    check("rst_res", r1, 32'h0);
    check("rst_c", {31'd0, c1}, 32'd0);
    check("rst_flags", {29'd0, busy1, stall1, done1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("lsl4",    2'b00, 32'h1000_000F, 8'd4,   1'b0, 32'h0000_00F0, 1'b1, 5,  1'b0);
    repeat (2) tick();
    check("hold_res", r1, 32'h0000_00F0);
    run_op("lsr32",   2'b01, 32'h8000_0001, 8'd32,  1'b0, 32'h0,         1'b1, 33, 1'b0);
    run_op("lsr40",   2'b01, 32'h8000_0001, 8'd40,  1'b1, 32'h0,         1'b0, 34, 1'b0);
    run_op("lsl32",   2'b00, 32'h0000_0003, 8'd32,  1'b0, 32'h0,         1'b1, 33, 1'b0);
    run_op("asr200",  2'b10, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 33, 1'b0);
    run_op("asr3",    2'b10, 32'h4000_0004, 8'd3,   1'b0, 32'h0800_0000, 1'b1, 4,  1'b0);
    run_op("ror36",   2'b11, 32'h0000_0001, 8'd36,  1'b1, 32'h1000_0000, 1'b0, 5,  1'b0);
    run_op("ror32",   2'b11, 32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 1,  1'b1);
    for (int t = 0; t < 4; t++) begin
      run_op($sformatf("zero_t%0d", t), 2'(t), 32'h1234_5678, 8'd0, 1'b1,
             32'h1234_5678, 1'b1, 1, 1'b1);
    end

    // Flush mid-shift, with an ignored start while shifting.
    @(negedge clk);
    shift_type = 2'b00; val_rm = 32'h1; rs_amount = 8'd20; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 25; i++) begin
      if (done1) dones++;
      if (i == 3) begin start = 1'b1; rs_amount = 8'd0; val_rm = 32'hDEAD; end
      if (i == 4) check("ign_start_stall", {31'd0, stall1}, 32'd1);
      if (i == 6) flush = 1'b1;
      if (i == 7) begin
        check("flush_busy", {31'd0, busy1}, 32'd0);
        check("flush_stall", {31'd0, stall1}, 32'd0);
      end
      tick();
      start = 1'b0; flush = 1'b0;
    end
    check("flush_no_done", 32'(dones), 32'd0);

    // Reset mid-operation.
    @(negedge clk);
    shift_type = 2'b00; val_rm = 32'hFFFF_FFFF; rs_amount = 8'd10; carry_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_res", r1, 32'h0);
    check("midrst_c", {31'd0, c1}, 32'd0);
    check("midrst_flags", {29'd0, busy1, stall1, done1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: second start lands in the DONE cycle of the first.
    @(negedge clk);
    shift_type = 2'b00; val_rm = 32'h1; rs_amount = 8'd2; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 20) begin tick(); cyc++; end
    check("b2b_a_lat", 32'(cyc), 32'd3);
    check("b2b_a_res", r1, 32'h4);
    shift_type = 2'b01; val_rm = 32'h84; rs_amount = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 20) begin tick(); cyc++; end
    check("b2b_b_lat", 32'(cyc), 32'd4);
    check("b2b_b_res", r1, 32'h10);
    check("b2b_b_c", {31'd0, c1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
